// File: rtl/monitor_semaforo_if.sv
// Lamp and monitor-result bundle between a two-street traffic-light controller
// and its safety monitor.
interface monitor_semaforo_if #(
  parameter int CNT_W = 16
);
  logic [1:0]       verde;
  logic [1:0]       amarillo;
  logic [1:0]       rojo;
  logic             clear;
  logic [1:0]       estado_a;
  logic [1:0]       estado_b;
  logic             err_conflicto;
  logic             err_codigo;
  logic             err_secuencia;
  logic             err_amarillo;
  logic             err_any;
  logic [CNT_W-1:0] ciclos;

  modport master (
    output verde, amarillo, rojo, clear,
    input  estado_a, estado_b, err_conflicto, err_codigo, err_secuencia,
           err_amarillo, err_any, ciclos
  );

  modport slave (
    input  verde, amarillo, rojo, clear,
    output estado_a, estado_b, err_conflicto, err_codigo, err_secuencia,
           err_amarillo, err_any, ciclos
  );
endinterface

// File: rtl/monitor_semaforo.sv
// Passive safety monitor for a two-street traffic light: decodes each street's
// phase and raises sticky flags on bad encoding, conflicts, bad order and yellow dwell.
module monitor_semaforo #(
  parameter int MIN_AMARILLO = 2,
  parameter int MAX_AMARILLO = 4,
  parameter int CNT_W        = 16
) (
  input logic               clk,
  input logic               reset,
  monitor_semaforo_if.slave bus
);
  localparam int CW = $clog2(MAX_AMARILLO + 2);
  localparam logic [CW-1:0]    MIN_C   = CW'(MIN_AMARILLO);
  localparam logic [CW-1:0]    SAT_C   = CW'(MAX_AMARILLO + 1);
  localparam logic [CW-1:0]    ONE_C   = CW'(1);
  localparam logic [CW-1:0]    ZERO_C  = {CW{1'b0}};
  localparam logic [CNT_W-1:0] CIC_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CIC_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CIC_0   = {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    PH_ROJO     = 2'b00,
    PH_VERDE    = 2'b01,
    PH_AMARILLO = 2'b10,
    PH_INVALIDO = 2'b11
  } phase_t;

  function automatic phase_t decode(input logic v, input logic a, input logic r);
    phase_t ph;
    case ({v, a, r})
      3'b100:  ph = PH_VERDE;
      3'b010:  ph = PH_AMARILLO;
      3'b001:  ph = PH_ROJO;
      default: ph = PH_INVALIDO;
    endcase
    return ph;
  endfunction

  function automatic logic illegal_step(input phase_t from_ph, input phase_t to_ph);
    logic bad;
    case ({from_ph, to_ph})
      {PH_VERDE, PH_ROJO},
      {PH_ROJO, PH_AMARILLO},
      {PH_AMARILLO, PH_VERDE}: bad = 1'b1;
      default:                 bad = 1'b0;
    endcase
    return bad;
  endfunction

  phase_t          w_ph        [2];
  phase_t          r_prev      [2];
  phase_t          w_prev_next [2];
  logic [CW-1:0]   r_cnt       [2];
  logic [CW-1:0]   w_cnt_next  [2];
  logic [1:0]      w_valid;
  logic [1:0]      w_seq;
  logic [1:0]      w_dwell;
  logic            w_conf;
  logic            w_cod;
  logic            w_inc;

  logic [1:0]       r_estado_a;
  logic [1:0]       r_estado_b;
  logic             r_err_conflicto;
  logic             r_err_codigo;
  logic             r_err_secuencia;
  logic             r_err_amarillo;
  logic [CNT_W-1:0] r_ciclos;

  // Per-street decode, transition legality and yellow dwell bookkeeping
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      w_ph[s]        = decode(bus.verde[s], bus.amarillo[s], bus.rojo[s]);
      w_valid[s]     = (w_ph[s] != PH_INVALIDO);
      w_prev_next[s] = r_prev[s];
      w_cnt_next[s]  = r_cnt[s];
      w_seq[s]       = 1'b0;
      w_dwell[s]     = 1'b0;
      if (w_valid[s]) begin
        w_prev_next[s] = w_ph[s];
        w_seq[s]       = illegal_step(r_prev[s], w_ph[s]);
        if (w_ph[s] == PH_AMARILLO) begin
          if (r_prev[s] != PH_AMARILLO) begin
            w_cnt_next[s] = ONE_C;
          end else if (r_cnt[s] != SAT_C) begin
            w_cnt_next[s] = r_cnt[s] + ONE_C;
          end else begin
            w_cnt_next[s] = r_cnt[s];
          end
          // Saturation makes the overstay flag fire on exactly one sample per phase
          w_dwell[s] = (w_cnt_next[s] == SAT_C) && (r_cnt[s] != SAT_C);
        end else if (r_prev[s] == PH_AMARILLO) begin
          w_dwell[s]    = (r_cnt[s] < MIN_C);
          w_cnt_next[s] = ZERO_C;
        end else begin
          w_cnt_next[s] = r_cnt[s];
        end
      end else begin
        w_prev_next[s] = r_prev[s];
      end
    end
  end

  // Cross-street checks and street-A cycle detection
  always_comb begin
    w_cod  = ~(w_valid[0] & w_valid[1]);
    w_conf = w_valid[0] & w_valid[1] & (w_ph[0] != PH_ROJO) & (w_ph[1] != PH_ROJO);
    w_inc  = w_valid[0] & (r_prev[0] == PH_ROJO) & (w_ph[0] == PH_VERDE);
  end

  // Last valid phase and dwell counter per street; untouched by clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < 2; s++) begin
        r_prev[s] <= PH_ROJO;
        r_cnt[s]  <= ZERO_C;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        r_prev[s] <= w_prev_next[s];
        r_cnt[s]  <= w_cnt_next[s];
      end
    end
  end

  // Registered phase outputs, sticky flags and saturating cycle counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estado_a      <= 2'b00;
      r_estado_b      <= 2'b00;
      r_err_conflicto <= 1'b0;
      r_err_codigo    <= 1'b0;
      r_err_secuencia <= 1'b0;
      r_err_amarillo  <= 1'b0;
      r_ciclos        <= CIC_0;
    end else begin
      r_estado_a      <= w_ph[0];
      r_estado_b      <= w_ph[1];
      // A violation in the clearing sample still sets its flag
      r_err_conflicto <= (r_err_conflicto & ~bus.clear) | w_conf;
      r_err_codigo    <= (r_err_codigo & ~bus.clear) | w_cod;
      r_err_secuencia <= (r_err_secuencia & ~bus.clear) | (|w_seq);
      r_err_amarillo  <= (r_err_amarillo & ~bus.clear) | (|w_dwell);
      if (bus.clear) begin
        r_ciclos <= w_inc ? CIC_ONE : CIC_0;
      end else if (w_inc && (r_ciclos != CIC_MAX)) begin
        r_ciclos <= r_ciclos + CIC_ONE;
      end else begin
        r_ciclos <= r_ciclos;
      end
    end
  end

  assign bus.estado_a      = r_estado_a;
  assign bus.estado_b      = r_estado_b;
  assign bus.err_conflicto = r_err_conflicto;
  assign bus.err_codigo    = r_err_codigo;
  assign bus.err_secuencia = r_err_secuencia;
  assign bus.err_amarillo  = r_err_amarillo;
  assign bus.err_any       = r_err_conflicto | r_err_codigo | r_err_secuencia | r_err_amarillo;
  assign bus.ciclos        = r_ciclos;

endmodule

// File: tb/tb_monitor_semaforo.sv
// Self-checking bench for monitor_semaforo: directed scenarios plus a random
// lamp walk, all compared against a rule-level reference model.
module tb_monitor_semaforo;
  localparam int MIN_A = 2;
  localparam int MAX_A = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] verde, amarillo, rojo;
  logic       clear;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  monitor_semaforo_if #(.CNT_W(16)) bus0 ();
  monitor_semaforo_if #(.CNT_W(2))  bus1 ();

  assign bus0.verde = verde;  assign bus0.amarillo = amarillo;
  assign bus0.rojo  = rojo;   assign bus0.clear    = clear;
  assign bus1.verde = verde;  assign bus1.amarillo = amarillo;
  assign bus1.rojo  = rojo;   assign bus1.clear    = clear;

  monitor_semaforo #(.MIN_AMARILLO(MIN_A), .MAX_AMARILLO(MAX_A), .CNT_W(16)) u_dut16 (
    .clk(clk), .reset(reset), .bus(bus0));
  monitor_semaforo #(.MIN_AMARILLO(MIN_A), .MAX_AMARILLO(MAX_A), .CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .bus(bus1));

  // Reference model: phases as letters R/G/Y/X, yellow run length unbounded
  byte        m_prev [2];
  int         m_run  [2];
  bit         m_conf, m_cod, m_seq, m_am;
  int         m_cic16, m_cic2;
  logic [1:0] m_est  [2];

  function automatic byte dec_lamp(input logic v, input logic a, input logic r);
    if (int'(v) + int'(a) + int'(r) != 1) return "X";
    else if (v) return "G";
    else if (a) return "Y";
    else return "R";
  endfunction

  function automatic logic [1:0] code_of(input byte p);
    if (p == "G") return 2'd1;
    else if (p == "Y") return 2'd2;
    else if (p == "X") return 2'd3;
    else return 2'd0;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_prev[s] = "R"; m_run[s] = 0; m_est[s] = 2'd0;
    end
    m_conf = 0; m_cod = 0; m_seq = 0; m_am = 0; m_cic16 = 0; m_cic2 = 0;
  endtask

  task automatic model_step();
    byte ph [2];
    bit n_conf, n_cod, n_seq, n_am, inc;
    n_conf = 0; n_cod = 0; n_seq = 0; n_am = 0; inc = 0;
    for (int s = 0; s < 2; s++) ph[s] = dec_lamp(verde[s], amarillo[s], rojo[s]);
    if (ph[0] == "X" || ph[1] == "X") n_cod = 1;
    if (ph[0] != "X" && ph[1] != "X" && ph[0] != "R" && ph[1] != "R") n_conf = 1;
    for (int s = 0; s < 2; s++) begin
      m_est[s] = code_of(ph[s]);
      if (ph[s] != "X") begin
        if (ph[s] != m_prev[s] && !(m_prev[s] == "R" && ph[s] == "G")
            && !(m_prev[s] == "G" && ph[s] == "Y") && !(m_prev[s] == "Y" && ph[s] == "R"))
          n_seq = 1;
        if (ph[s] == "Y") begin
          m_run[s] = (m_prev[s] == "Y") ? m_run[s] + 1 : 1;
          if (m_run[s] == MAX_A + 1) n_am = 1;
        end else if (m_prev[s] == "Y") begin
          if (m_run[s] < MIN_A) n_am = 1;
          m_run[s] = 0;
        end
        if (s == 0 && m_prev[s] == "R" && ph[s] == "G") inc = 1;
        m_prev[s] = ph[s];
      end
    end
    m_conf = (clear ? 1'b0 : m_conf) | n_conf;
    m_cod  = (clear ? 1'b0 : m_cod)  | n_cod;
    m_seq  = (clear ? 1'b0 : m_seq)  | n_seq;
    m_am   = (clear ? 1'b0 : m_am)   | n_am;
    if (clear) begin
      m_cic16 = inc ? 1 : 0; m_cic2 = inc ? 1 : 0;
    end else if (inc) begin
      if (m_cic16 < 65535) m_cic16++;
      if (m_cic2 < 3) m_cic2++;
    end
  endtask

  task automatic set_street(input int s, input byte p);
    verde[s] = (p == "G"); amarillo[s] = (p == "Y"); rojo[s] = (p == "R");
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1; step(); clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0;
    set_street(0, "R"); set_street(1, "R");
    model_reset();
    #2;
    total++; if (bus0.estado_a !== 2'b00) begin bad++; $display("FAIL reset_estado_a: got %0d want 0", bus0.estado_a); end
    total++; if (bus0.estado_b !== 2'b00) begin bad++; $display("FAIL reset_estado_b: got %0d want 0", bus0.estado_b); end
    total++; if (bus0.err_any !== 1'b0) begin bad++; $display("FAIL reset_err_any: got %0b want 0", bus0.err_any); end
    total++; if (bus0.ciclos !== 16'd0) begin bad++; $display("FAIL reset_ciclos: got %0d want 0", bus0.ciclos); end
    @(posedge clk); #1;
    reset = 1'b0;
    step();
    total++; if (bus0.err_any !== 1'b0) begin bad++; $display("FAIL post_reset_err_any: got %0b want 0", bus0.err_any); end
  endtask

  task automatic test_legal_cycle();
    string seq = "RRRGGGYYYR";
    for (int st = 0; st < 2; st++) begin
      for (int i = 0; i < seq.len(); i++) begin
        set_street(st, seq[i]); set_street(1 - st, "R");
        step();
        total++; if (bus0.estado_a !== m_est[0]) begin bad++; $display("FAIL legal_estado_a: got %0d want %0d", bus0.estado_a, m_est[0]); end
        total++; if (bus0.estado_b !== m_est[1]) begin bad++; $display("FAIL legal_estado_b: got %0d want %0d", bus0.estado_b, m_est[1]); end
        total++; if (bus0.err_any !== 1'b0) begin bad++; $display("FAIL legal_err_any: got %0b want 0", bus0.err_any); end
      end
    end
    total++; if (bus0.ciclos !== 16'd1) begin bad++; $display("FAIL legal_ciclos: got %0d want 1", bus0.ciclos); end
  endtask

  task automatic test_conflict_clear();
    verde = 2'b11; amarillo = 2'b00; rojo = 2'b00;
    step();
    total++; if (bus0.err_conflicto !== 1'b1) begin bad++; $display("FAIL conflict_set: got %0b want 1", bus0.err_conflicto); end
    total++; if (bus0.err_any !== 1'b1) begin bad++; $display("FAIL conflict_any: got %0b want 1", bus0.err_any); end
    set_street(0, "R"); set_street(1, "R");
    step();
    total++; if (bus0.err_conflicto !== 1'b1) begin bad++; $display("FAIL conflict_sticky: got %0b want 1", bus0.err_conflicto); end
    do_clear();
    total++; if (bus0.err_conflicto !== 1'b0) begin bad++; $display("FAIL conflict_clear: got %0b want 0", bus0.err_conflicto); end
    total++; if (bus0.err_any !== 1'b0) begin bad++; $display("FAIL clear_any: got %0b want 0", bus0.err_any); end
  endtask

  task automatic test_dwell();
    set_street(1, "R");
    set_street(0, "G"); step();
    set_street(0, "Y"); step();
    total++; if (bus0.err_amarillo !== 1'b0) begin bad++; $display("FAIL dwell_short_early: got %0b want 0", bus0.err_amarillo); end
    set_street(0, "R"); step();
    total++; if (bus0.err_amarillo !== 1'b1) begin bad++; $display("FAIL dwell_short: got %0b want 1", bus0.err_amarillo); end
    do_clear();
    set_street(0, "G"); step();
    for (int k = 1; k <= 6; k++) begin
      set_street(0, "Y"); step();
      total++; if (bus0.err_amarillo !== (k >= MAX_A + 1)) begin bad++; $display("FAIL dwell_long_%0d: got %0b want %0b", k, bus0.err_amarillo, (k >= MAX_A + 1)); end
    end
    set_street(0, "R"); clear = 1'b1; step(); clear = 1'b0;
    total++; if (bus0.err_any !== 1'b0) begin bad++; $display("FAIL dwell_clear: got %0b want 0", bus0.err_any); end
  endtask

  task automatic test_sequence();
    set_street(1, "R");
    set_street(0, "G"); step();
    set_street(0, "R"); step();
    total++; if (bus0.err_secuencia !== 1'b1) begin bad++; $display("FAIL seq_g2r: got %0b want 1", bus0.err_secuencia); end
    total++; if (bus0.err_codigo !== 1'b0) begin bad++; $display("FAIL seq_g2r_cod: got %0b want 0", bus0.err_codigo); end
    do_clear();
    set_street(0, "Y"); step();
    total++; if (bus0.err_secuencia !== 1'b1) begin bad++; $display("FAIL seq_r2y: got %0b want 1", bus0.err_secuencia); end
    total++; if (bus0.err_codigo !== 1'b0) begin bad++; $display("FAIL seq_r2y_cod: got %0b want 0", bus0.err_codigo); end
    step();
    set_street(0, "R"); step();
    do_clear();
  endtask

  task automatic test_encoding();
    set_street(1, "R");
    set_street(0, "G"); step();
    verde[0] = 1'b1; amarillo[0] = 1'b1; rojo[0] = 1'b0; step();
    total++; if (bus0.estado_a !== 2'b11) begin bad++; $display("FAIL enc_estado: got %0d want 3", bus0.estado_a); end
    total++; if (bus0.err_codigo !== 1'b1) begin bad++; $display("FAIL enc_cod: got %0b want 1", bus0.err_codigo); end
    set_street(0, "G"); step();
    total++; if (bus0.estado_a !== 2'b01) begin bad++; $display("FAIL enc_back: got %0d want 1", bus0.estado_a); end
    total++; if (bus0.err_secuencia !== 1'b0) begin bad++; $display("FAIL enc_seq: got %0b want 0", bus0.err_secuencia); end
    set_street(0, "Y"); step(); step();
    set_street(0, "R"); step();
    do_clear();
  endtask

  task automatic test_async_reset_sat();
    set_street(1, "R");
    set_street(0, "G"); step();
    set_street(0, "Y"); step();
    #3; reset = 1'b1; #1;
    model_reset();
    total++; if (bus0.estado_a !== 2'b00) begin bad++; $display("FAIL async_estado: got %0d want 0", bus0.estado_a); end
    total++; if (bus0.ciclos !== 16'd0) begin bad++; $display("FAIL async_ciclos: got %0d want 0", bus0.ciclos); end
    total++; if (bus0.err_any !== 1'b0) begin bad++; $display("FAIL async_any: got %0b want 0", bus0.err_any); end
    @(negedge clk); reset = 1'b0;
    step();
    total++; if (bus0.err_secuencia !== 1'b1) begin bad++; $display("FAIL after_reset_seq: got %0b want 1", bus0.err_secuencia); end
    step();
    set_street(0, "R"); step();
    do_clear();
    for (int c = 0; c < 5; c++) begin
      set_street(0, "G"); step();
      set_street(0, "Y"); step(); step();
      set_street(0, "R"); step();
    end
    total++; if (bus1.ciclos !== 2'd3) begin bad++; $display("FAIL sat_ciclos2: got %0d want 3", bus1.ciclos); end
    total++; if (bus0.ciclos !== 16'd5) begin bad++; $display("FAIL sat_ciclos16: got %0d want 5", bus0.ciclos); end
    total++; if (bus0.err_any !== 1'b0) begin bad++; $display("FAIL sat_err_any: got %0b want 0", bus0.err_any); end
  endtask

  task automatic test_random();
    byte cur [2];
    logic [2:0] raw;
    int r;
    cur[0] = "R"; cur[1] = "R";
    for (int n = 0; n < 400; n++) begin
      for (int s = 0; s < 2; s++) begin
        r = $urandom_range(0, 31);
        if (r == 0) begin
          raw = 3'($urandom_range(0, 7));
          verde[s] = raw[2]; amarillo[s] = raw[1]; rojo[s] = raw[0];
        end else begin
          if (r >= 30) cur[s] = (r == 30) ? "Y" : "G";
          else if (r >= 20) cur[s] = (cur[s] == "R") ? "G" : (cur[s] == "G") ? "Y" : "R";
          set_street(s, cur[s]);
        end
      end
      clear = ($urandom_range(0, 15) == 0);
      step();
      total++; if (bus0.estado_a !== m_est[0]) begin bad++; $display("FAIL rnd_estado_a @%0d: got %0d want %0d", n, bus0.estado_a, m_est[0]); end
      total++; if (bus0.estado_b !== m_est[1]) begin bad++; $display("FAIL rnd_estado_b @%0d: got %0d want %0d", n, bus0.estado_b, m_est[1]); end
      total++; if (bus0.err_conflicto !== m_conf) begin bad++; $display("FAIL rnd_conf @%0d: got %0b want %0b", n, bus0.err_conflicto, m_conf); end
      total++; if (bus0.err_codigo !== m_cod) begin bad++; $display("FAIL rnd_cod @%0d: got %0b want %0b", n, bus0.err_codigo, m_cod); end
      total++; if (bus0.err_secuencia !== m_seq) begin bad++; $display("FAIL rnd_seq @%0d: got %0b want %0b", n, bus0.err_secuencia, m_seq); end
      total++; if (bus0.err_amarillo !== m_am) begin bad++; $display("FAIL rnd_am @%0d: got %0b want %0b", n, bus0.err_amarillo, m_am); end
      total++; if (bus0.err_any !== (m_conf | m_cod | m_seq | m_am)) begin bad++; $display("FAIL rnd_any @%0d: got %0b", n, bus0.err_any); end
      total++; if (bus0.ciclos !== 16'(m_cic16)) begin bad++; $display("FAIL rnd_ciclos16 @%0d: got %0d want %0d", n, bus0.ciclos, m_cic16); end
      total++; if (bus1.ciclos !== 2'(m_cic2)) begin bad++; $display("FAIL rnd_ciclos2 @%0d: got %0d want %0d", n, bus1.ciclos, m_cic2); end
    end
    clear = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_legal_cycle();
    test_conflict_clear();
    test_dwell();
    test_sequence();
    test_encoding();
    test_async_reset_sat();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/monitor_semaforo.md
# monitor_semaforo

Passive checker that sits on the light outputs of the two-street traffic-light controller (`verde[1:0]`, `amarillo[1:0]`, `rojo[1:0]`; index 0 = street A, index 1 = street B). Each cycle it decodes the phase of each street and checks four things: encoding, cross-street conflict, phase order and yellow dwell time. Violations are reported on sticky error flags, and completed street-A cycles are counted. It is used in simulation benches and on-board as a safety monitor, on the same clock as the controller, so no input synchronisation is needed.

## Interface
- `MIN_AMARILLO`, default 2: minimum consecutive yellow samples per yellow phase.
- `MAX_AMARILLO`, default 4: maximum consecutive yellow samples per yellow phase; must be ≥ `MIN_AMARILLO`.
- `CNT_W`, default 16: width of `ciclos`.
- `clk`, in, 1: system clock, rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `verde`, in, 2: green lamp per street.
- `amarillo`, in, 2: yellow lamp per street.
- `rojo`, in, 2: red lamp per street.
- `clear`, in, 1: synchronous clear of all error flags and `ciclos`.
- `estado_a`, out, 2: registered decoded phase of street A; 00 rojo, 01 verde, 10 amarillo, 11 invalid.
- `estado_b`, out, 2: same, street B.
- `err_conflicto`, out, 1: sticky flag; both streets non-red.
- `err_codigo`, out, 1: sticky flag; illegal lamp encoding.
- `err_secuencia`, out, 1: sticky flag; illegal phase transition.
- `err_amarillo`, out, 1: sticky flag; yellow dwell out of bounds.
- `err_any`, out, 1: OR of the four error flags.
- `ciclos`, out, `CNT_W`: count of street-A rojo→verde transitions, saturating.

## Operation
- Decoding per street i: the triple {verde[i], amarillo[i], rojo[i]} must be one-hot. Any other pattern (000, or two or more bits set) decodes to invalid (11).
- `prev_i` holds the last valid phase of street i. Reset sets both to rojo. `prev_i` updates only on valid samples.
- Encoding check: an invalid sample on either street sets `err_codigo`. That street's transition and dwell checks are skipped for that sample, and its `prev` and dwell counter hold.
- Legal per-street transitions: rojo→verde, verde→amarillo, amarillo→rojo, plus hold in any phase. All other changes set `err_secuencia`: verde→rojo, rojo→amarillo, amarillo→verde.
- Conflict check: if both streets decode valid and neither is rojo, set `err_conflicto`. All-red on both streets is legal.
- Yellow dwell, per street, with counter `cnt_i` of width clog2(`MAX_AMARILLO`+2):
  - Entering amarillo loads `cnt_i` = 1.
  - Holding amarillo increments `cnt_i`, saturating at `MAX_AMARILLO`+1.
  - Sample number `MAX_AMARILLO`+1 of a continuous yellow sets `err_amarillo`; this is flagged once per phase.
  - Leaving amarillo with `cnt_i` < `MIN_AMARILLO` sets `err_amarillo`.
  - Leaving amarillo clears `cnt_i` to 0.
- `ciclos` increments on each valid street-A rojo→verde and saturates at all-ones.
- Error flags are sticky until `clear` or `reset`.
- If `clear` and a new violation occur in the same cycle, the violation wins: that flag reads 1 and the other flags clear. `clear` zeroes `ciclos`, but a same-cycle increment loads 1.
- `clear` does not touch `prev_i`, `cnt_i` or `estado_*`.

## Timing
- All checks are evaluated on the input sample at rising edge k. Flags, `estado_*` and `ciclos` reflect that sample after edge k (latency 1 cycle from input change).
- `err_any` is combinational from the registered flags; it adds no extra latency.
- Reset values:
  - `estado_a` = `estado_b` = 00.
  - All `err_*` = 0.
  - `ciclos` = 0.
  - `prev` = rojo/rojo.
  - `cnt` = 0.
- `reset` asserted mid-phase clears everything immediately, without waiting for a clock edge. The first sample after release is compared against rojo, so amarillo then gives `err_secuencia` and verde increments `ciclos` (street A).
- Multiple violations in one sample set all applicable flags in the same cycle.

## Test plan
- **Legal cycle:** reset, then apply A: rojo3 verde3 amarillo3 rojo, with B rojo throughout; then the same sequence on B with A rojo → no flags raised, `ciclos`=1, `estado_a` goes 00→01→10→00, each change one cycle after the input change.
- **Conflict and clear:** apply verde=11, rojo=00 → `err_conflicto`=1 and `err_any`=1 one cycle later; the flag stays set after legal inputs return; pulse `clear` → 0 next cycle.
- **Yellow dwell:** A amarillo for 1 cycle then rojo → `err_amarillo`=1. Separately, A amarillo held for 6 cycles → `err_amarillo` rises after the 5th yellow sample.
- **Illegal sequence:** A verde→rojo → `err_secuencia`. After clear, A rojo→amarillo → `err_secuencia` again. `err_codigo` stays 0 in both cases.
- **Bad encoding:** verde[0]=amarillo[0]=1 for one cycle, then the previous valid phase again → `err_codigo`=1, `estado_a`=11 for one cycle, `err_secuencia`=0.
- **Async reset and saturation:** assert `reset` mid-yellow between clock edges → all outputs 0 immediately. With `CNT_W`=2, run 5 legal A cycles → `ciclos` holds at 3.
